// File: rtl/seg7_pkg.sv
// Shared definitions for the scanned 7-segment decoder:
// segment patterns, FSM state type and the pattern-to-nibble lookup.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h18;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  // Returns {err, blank, nibble}.
  function automatic logic [5:0] seg7_to_nibble(
    input logic [6:0] p
  );
    logic [5:0] r;
    r = {2'b10, 4'h0};
    case (p)
      SEG_0: r = {2'b00, 4'h0};
      SEG_1: r = {2'b00, 4'h1};
      SEG_2: r = {2'b00, 4'h2};
      SEG_3: r = {2'b00, 4'h3};
      SEG_4: r = {2'b00, 4'h4};
      SEG_5: r = {2'b00, 4'h5};
      SEG_6: r = {2'b00, 4'h6};
      SEG_7: r = {2'b00, 4'h7};
      SEG_8: r = {2'b00, 4'h8};
      SEG_9: r = {2'b00, 4'h9};
      SEG_A: r = {2'b00, 4'hA};
      SEG_B: r = {2'b00, 4'hB};
      SEG_C: r = {2'b00, 4'hC};
      SEG_D: r = {2'b00, 4'hD};
      SEG_E: r = {2'b00, 4'hE};
      SEG_F: r = {2'b00, 4'hF};
`ifdef SEG7_BLANK_EN
      SEG_BLANK: r = {2'b01, 4'h0};
`endif
      default: r = {2'b10, 4'h0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of one active-low 7-segment pattern.
// Ports: seg[6:0] in; nibble[3:0], err, blank out.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       err,
  output logic       blank
);

  logic [5:0] r;

  assign r      = seg7_to_nibble(seg);
  assign err    = r[5];
  assign blank  = r[4];
  assign nibble = r[3:0];

endmodule

// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed active-low 7-seg bus, decodes each settled digit
// and presents NDIG-digit frames on a valid/ready output.
// Ports: clock, reset (sync, high), seg[6:0], dig_sel[NDIG-1:0] in;
//  out_valid, out_value[4*NDIG-1:0], out_err, out_blank, overflow out;
//  out_ready in. Macro SEG7_BLANK_EN enables 7'h7F as a blank digit.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [6:0]        seg,
  input  logic [NDIG-1:0]   dig_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] out_value,
  output logic [NDIG-1:0]   out_err,
  output logic [NDIG-1:0]   out_blank,
  output logic              overflow
);

  localparam int CW = $clog2(STABLE_CYC + 1);

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [6:0]        seg_q, seg_nx;
  logic [NDIG-1:0]   dig_q, dig_nx;
  logic [NDIG-1:0]   mask, mask_nx;
  logic [4*NDIG-1:0] val_buf, val_nx;
  logic [NDIG-1:0]   err_buf, err_nx;
  logic [NDIG-1:0]   blk_buf, blk_nx;
  logic [NDIG-1:0]   blank_q;
  logic [3:0]        dec_nib;
  logic              dec_err;
  logic              dec_blank;
  logic              sample;
  logic              onehot;
  logic              changed;
  logic              complete;
  logic              load;

  seg7_pattern_decode u_dec (
    .seg    (seg_q),
    .nibble (dec_nib),
    .err    (dec_err),
    .blank  (dec_blank)
  );

  assign onehot  = $onehot(dig_sel);
  assign changed = (seg != seg_q) || (dig_sel != dig_q);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    seg_nx   = seg_q;
    dig_nx   = dig_q;
    sample   = 1'b0;
    case (state)
      IDLE: begin
        if (onehot) begin
          state_nx = SETTLE;
          cnt_nx   = CW'(1);
          seg_nx   = seg;
          dig_nx   = dig_sel;
        end
      end
      SETTLE: begin
        if (changed) begin
          state_nx = onehot ? SETTLE : IDLE;
          cnt_nx   = CW'(1);
          seg_nx   = seg;
          dig_nx   = dig_sel;
        end else if (cnt == CW'(STABLE_CYC)) begin
          sample   = 1'b1;
          state_nx = HOLD;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      HOLD: begin
        // One sample per dwell; only a bus change re-arms.
        if (changed) begin
          state_nx = onehot ? SETTLE : IDLE;
          cnt_nx   = CW'(1);
          seg_nx   = seg;
          dig_nx   = dig_sel;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    val_nx  = val_buf;
    err_nx  = err_buf;
    blk_nx  = blk_buf;
    mask_nx = mask;
    for (int i = 0; i < NDIG; i++) begin
      if (sample && dig_q[i]) begin
        val_nx[4*i +: 4] = dec_nib;
        err_nx[i]        = dec_err;
        blk_nx[i]        = dec_blank;
        mask_nx[i]       = 1'b1;
      end
    end
  end

  assign complete = sample && (&mask_nx);
  assign load     = complete && (!out_valid || out_ready);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      seg_q     <= '0;
      dig_q     <= '0;
      mask      <= '0;
      val_buf   <= '0;
      err_buf   <= '0;
      blk_buf   <= '0;
      out_valid <= 1'b0;
      out_value <= '0;
      out_err   <= '0;
      blank_q   <= '0;
      overflow  <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      seg_q   <= seg_nx;
      dig_q   <= dig_nx;
      val_buf <= val_nx;
      err_buf <= err_nx;
      blk_buf <= blk_nx;
      mask    <= complete ? '0 : mask_nx;
      if (load) begin
        out_valid <= 1'b1;
        out_value <= val_nx;
        out_err   <= err_nx;
        blank_q   <= blk_nx;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (complete && !load) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef SEG7_BLANK_EN
  assign out_blank = blank_q;
`else
  assign out_blank = '0;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder (NDIG=4, STABLE_CYC=8).
// Expected frames are queued by the stimulus; a monitor checks handshakes.
module tb_seg7_scan_decoder;

  typedef struct packed {
    logic [15:0] v;
    logic [3:0]  e;
    logic [3:0]  b;
  } frame_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_value;
  logic [3:0]  out_err;
  logic [3:0]  out_blank;
  logic        overflow;

  int n_vec = 0;
  int n_mis = 0;
  frame_t sb[$];

  seg7_scan_decoder #(.NDIG(4), .STABLE_CYC(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .seg       (seg),
    .dig_sel   (dig_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_err   (out_err),
    .out_blank (out_blank),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      frame_t exp;
      n_vec++;
      if (sb.size() == 0) begin
        n_mis++;
        $display("FAIL unexpected_frame: got value=%h err=%b blank=%b, required none",
                 out_value, out_err, out_blank);
      end else begin
        exp = sb.pop_front();
        if (out_value !== exp.v || out_err !== exp.e || out_blank !== exp.b) begin
          n_mis++;
          $display("FAIL frame: got value=%h err=%b blank=%b, required value=%h err=%b blank=%b",
                   out_value, out_err, out_blank, exp.v, exp.e, exp.b);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic scan(input int idx, input logic [6:0] p, input int n);
    dig_sel = 4'b0001 << idx;
    seg     = p;
    step(n);
  endtask

  task automatic idle(input int n);
    dig_sel = 4'b0000;
    seg     = 7'h7F;
    step(n);
  endtask

  task automatic push(input logic [15:0] v, input logic [3:0] e, input logic [3:0] b);
    frame_t f;
    f.v = v;
    f.e = e;
    f.b = b;
    sb.push_back(f);
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      step(1);
      t++;
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_mis++;
      $display("FAIL %s_timeout: got %0d frames pending, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_valid"}, 32'(out_valid), 32'h0);
    check({name, "_value"}, 32'(out_value), 32'h0);
    check({name, "_err"}, 32'(out_err), 32'h0);
    check({name, "_blank"}, 32'(out_blank), 32'h0);
    check({name, "_ovf"}, 32'(overflow), 32'h0);
  endtask

  initial begin
    reset     = 1'b1;
    seg       = 7'h7F;
    dig_sel   = 4'b0000;
    out_ready = 1'b1;
    step(2);
    check_zero("reset");
    reset = 1'b0;
    idle(3);

    // Basic frame: digit3..0 = 5,3,2,1.
    push(16'h5321, 4'h0, 4'h0);
    scan(0, 7'h79, 10);
    scan(1, 7'h24, 10);
    scan(2, 7'h30, 10);
    scan(3, 7'h12, 10);
    idle(4);
    wait_drain("basic");
    check("valid_drop", 32'(out_valid), 32'h0);

    // Glitch: 0 shown briefly, then 8 settles on digit 0.
    push(16'h0008, 4'h0, 4'h0);
    scan(0, 7'h40, 5);
    scan(0, 7'h00, 10);
    scan(1, 7'h40, 10);
    scan(2, 7'h40, 10);
    scan(3, 7'h40, 10);
    idle(4);
    wait_drain("glitch");

    // Illegal select: nothing sampled.
    dig_sel = 4'b0011;
    seg     = 7'h79;
    step(20);
    idle(4);
    check("illegal_sel", 32'(out_valid), 32'h0);

`ifdef SEG7_BLANK_EN
    push(16'hE0EE, 4'b0000, 4'b0100);
`else
    push(16'hE0EE, 4'b0100, 4'b0000);
`endif
    scan(0, 7'h06, 10);
    scan(1, 7'h06, 10);
    scan(2, 7'h7F, 10);
    scan(3, 7'h06, 10);
    idle(4);
    wait_drain("blank_or_err");

`ifdef SEG7_BLANK_EN
    push(16'h0000, 4'b0000, 4'b1000);
    scan(0, 7'h40, 10);
    scan(1, 7'h40, 10);
    scan(2, 7'h40, 10);
    scan(3, 7'h7F, 10);
    idle(4);
    wait_drain("blank_en");
`endif

    // Backpressure: second frame overflows and is dropped.
    out_ready = 1'b0;
    push(16'h4321, 4'h0, 4'h0);
    scan(0, 7'h79, 10);
    scan(1, 7'h24, 10);
    scan(2, 7'h30, 10);
    scan(3, 7'h19, 10);
    idle(4);
    check("bp_ovf_first", 32'(overflow), 32'h0);
    scan(0, 7'h00, 10);
    scan(1, 7'h00, 10);
    scan(2, 7'h00, 10);
    scan(3, 7'h00, 10);
    idle(4);
    check("bp_ovf", 32'(overflow), 32'h1);
    check("bp_valid", 32'(out_valid), 32'h1);
    check("bp_value", 32'(out_value), 32'h4321);
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("bp_valid_drop", 32'(out_valid), 32'h0);
    check("bp_ovf_sticky", 32'(overflow), 32'h1);
    wait_drain("bp");

    // Reset mid-frame during SETTLE on digit 2.
    scan(0, 7'h08, 10);
    scan(1, 7'h03, 10);
    scan(2, 7'h46, 4);
    reset = 1'b1;
    step(2);
    check_zero("midreset");
    dig_sel = 4'b0000;
    step(1);
    reset = 1'b0;
    idle(2);
    scan(2, 7'h46, 10);
    scan(3, 7'h21, 10);
    idle(5);
    check("partial_no_valid", 32'(out_valid), 32'h0);
    push(16'hDCBA, 4'h0, 4'h0);
    scan(0, 7'h08, 10);
    scan(1, 7'h03, 10);
    scan(2, 7'h46, 10);
    scan(3, 7'h21, 10);
    idle(4);
    wait_drain("fresh");

    idle(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
